// File: rtl/encoder_pkg.sv
// Shared types and constants for the 4-to-2 pending-request encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package encoder_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    // One flop: IDLE means no code is on offer, PRESENT means Y holds a valid code.
    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Expands an index into the request bit it refers to.
    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/pri_enc4.sv
// Priority pick over 4 request bits, searching downward from a start index with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module pri_enc4
    import encoder_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    // Walk start, start-1, ... (mod 4); the first set bit wins.
    always_comb begin
        idx_o = start_i;
        any_o = 1'b0;
        cand  = start_i;
        for (int k = 0; k < N_REQ; k++) begin
            cand = start_i - IDX_W'(k);
            if (!any_o && req_i[cand]) begin
                idx_o = cand;
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder4to2_pend.sv
// Collects request bits into a pending set and offers their encoded index one at a time.
// Latency: a request captured at edge k is offered as Y/V right after edge k.
// Backpressure: with RDY=0 the offered code holds (no preemption); requests keep accumulating.
// Build option: define ENCODER_ROUND_ROBIN_EN for rotating priority; otherwise highest index wins.
module encoder4to2_pend
    import encoder_pkg::*;
#(
    parameter logic [IDX_W-1:0] IDLE_CODE = 2'b00
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_REQ-1:0] D,
    input  logic             EN,
    input  logic             RDY,
    output logic [IDX_W-1:0] Y,
    output logic             V,
    output logic [N_REQ-1:0] PEND,
    output logic             OVF
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] y_q, y_d;
    logic             v_q, v_d;
    logic [N_REQ-1:0] pend_q, pend_d;
    logic             ovf_q, ovf_d;

    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] cap;
    logic             grant;
    logic [IDX_W-1:0] start_idx;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    // Pending set: granted bit drops out, newly captured bits join; a new request beats a same-edge clear.
    always_comb begin
        grant  = v_q & RDY;
        clr    = grant ? onehot(y_q) : '0;
        cap    = EN ? D : '0;
        pend_d = (pend_q & ~clr) | cap;
        ovf_d  = ovf_q | (|(cap & pend_q & ~clr));
    end

`ifdef ENCODER_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Pointer remembers the last granted index; the grant in this very cycle takes effect immediately.
    always_comb begin
        ptr_d     = grant ? y_q : ptr_q;
        start_idx = ptr_d - IDX_W'(1);
    end

    // Rotation pointer register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: always start the search at the highest index.
    always_comb begin
        start_idx = IDX_W'(N_REQ - 1);
    end
`endif

    pri_enc4 u_pri_enc4 (
        .req_i   (pend_d),
        .start_i (start_idx),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Next state and next offered code; a held offer is never replaced until it is accepted.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        v_d     = v_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = PRESENT;
                    y_d     = pick_idx;
                    v_d     = 1'b1;
                end else begin
                    y_d = IDLE_CODE;
                    v_d = 1'b0;
                end
            end
            PRESENT: begin
                if (RDY) begin
                    if (pick_any) begin
                        y_d = pick_idx;
                        v_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        y_d     = IDLE_CODE;
                        v_d     = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                y_d     = IDLE_CODE;
                v_d     = 1'b0;
            end
        endcase
    end

    // State, offer, pending set and sticky overflow registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            y_q     <= IDLE_CODE;
            v_q     <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            v_q     <= v_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Y    = y_q;
    assign V    = v_q;
    assign PEND = pend_q;
    assign OVF  = ovf_q;

endmodule

// File: tb/tb_encoder4to2_pend.sv
// Directed bench for encoder4to2_pend with hand-computed expectations.
// Inputs change #1 after the rising edge; outputs are sampled there too.
// Build with ENCODER_ROUND_ROBIN_EN to exercise the rotating-priority expectations.
module tb_encoder4to2_pend;

    logic       clk;
    logic       rst_n;
    logic [3:0] d;
    logic       en;
    logic       rdy;
    logic [1:0] y;
    logic       v;
    logic [3:0] pend;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    encoder4to2_pend #(.IDLE_CODE(2'b00)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .D     (d),
        .EN    (en),
        .RDY   (rdy),
        .Y     (y),
        .V     (v),
        .PEND  (pend),
        .OVF   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare all four outputs in one go.
    task automatic chk_all(input string tag, input logic [1:0] ey, input logic ev,
                           input logic [3:0] ep, input logic eo);
        chk({tag, ".Y"},    {6'd0, y},    {6'd0, ey});
        chk({tag, ".V"},    {7'd0, v},    {7'd0, ev});
        chk({tag, ".PEND"}, {4'd0, pend}, {4'd0, ep});
        chk({tag, ".OVF"},  {7'd0, ovf},  {7'd0, eo});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        d     = 4'b0000;
        en    = 1'b0;
        rdy   = 1'b0;
        #2;
        chk_all("reset", 2'd0, 1'b0, 4'b0000, 1'b0);
        do_reset();
        chk_all("post_reset", 2'd0, 1'b0, 4'b0000, 1'b0);

        // Single request held for five cycles, then accepted.
        en = 1'b1; d = 4'b0100; rdy = 1'b0;
        step();
        chk_all("single_cap", 2'd2, 1'b1, 4'b0100, 1'b0);
        en = 1'b0; d = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all("single_hold", 2'd2, 1'b1, 4'b0100, 1'b0);
        end
        rdy = 1'b1;
        step();
        chk_all("single_acc", 2'd0, 1'b0, 4'b0000, 1'b0);

        // RDY while idle and EN with D=0 do nothing.
        en = 1'b1; d = 4'b0000;
        step();
        chk_all("idle_noop", 2'd0, 1'b0, 4'b0000, 1'b0);

        // Multi-hot with RDY held: 3,1,0 then idle.
        d = 4'b1011;
        step();
        chk_all("multi_3", 2'd3, 1'b1, 4'b1011, 1'b0);
        en = 1'b0; d = 4'b0000;
        step();
        chk_all("multi_1", 2'd1, 1'b1, 4'b0011, 1'b0);
        step();
        chk_all("multi_0", 2'd0, 1'b1, 4'b0001, 1'b0);
        step();
        chk_all("multi_end", 2'd0, 1'b0, 4'b0000, 1'b0);

        // No preemption: code 1 stays while a higher request arrives.
        rdy = 1'b0; en = 1'b1; d = 4'b0010;
        step();
        chk_all("nopre_cap", 2'd1, 1'b1, 4'b0010, 1'b0);
        d = 4'b1000;
        step();
        chk_all("nopre_hold", 2'd1, 1'b1, 4'b1010, 1'b0);
        en = 1'b0; d = 4'b0000;
        step();
        chk_all("nopre_hold2", 2'd1, 1'b1, 4'b1010, 1'b0);
        rdy = 1'b1;
        step();
        chk_all("nopre_next", 2'd3, 1'b1, 4'b1000, 1'b0);
        step();
        chk_all("nopre_end", 2'd0, 1'b0, 4'b0000, 1'b0);

        // Overflow: repeat request on a pending, unaccepted bit.
        rdy = 1'b0; en = 1'b1; d = 4'b0010;
        step();
        chk_all("ovf_cap", 2'd1, 1'b1, 4'b0010, 1'b0);
        step();
        chk_all("ovf_set", 2'd1, 1'b1, 4'b0010, 1'b1);
        en = 1'b0; d = 4'b0000;
        step();
        chk_all("ovf_sticky", 2'd1, 1'b1, 4'b0010, 1'b1);
        rdy = 1'b1;
        step();
        chk_all("ovf_sticky2", 2'd0, 1'b0, 4'b0000, 1'b1);

        // Same-edge clear and capture of bit 1: bit stays, no overflow.
        rdy = 1'b0;
        do_reset();
        chk_all("rst_clears_ovf", 2'd0, 1'b0, 4'b0000, 1'b0);
        en = 1'b1; d = 4'b0010;
        step();
        chk_all("same_cap", 2'd1, 1'b1, 4'b0010, 1'b0);
        rdy = 1'b1;
        step();
        chk_all("same_edge", 2'd1, 1'b1, 4'b0010, 1'b0);
        rdy = 1'b0; d = 4'b1000;
        step();
        chk_all("pre_reset", 2'd1, 1'b1, 4'b1010, 1'b0);

        // Asynchronous reset in the middle of a cycle.
        en = 1'b0; d = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 2'd0, 1'b0, 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_all("after_rst", 2'd0, 1'b0, 4'b0000, 1'b0);

        // All four requested, then bit 3 re-requested on the first grant, RDY held.
        en = 1'b1; d = 4'b1111; rdy = 1'b0;
        step();
        chk_all("all_cap", 2'd3, 1'b1, 4'b1111, 1'b0);
        d = 4'b1000; rdy = 1'b1;
        step();
`ifdef ENCODER_ROUND_ROBIN_EN
        chk_all("rr_2", 2'd2, 1'b1, 4'b1111, 1'b0);
        en = 1'b0; d = 4'b0000;
        step();
        chk_all("rr_1", 2'd1, 1'b1, 4'b1011, 1'b0);
        step();
        chk_all("rr_0", 2'd0, 1'b1, 4'b1001, 1'b0);
        step();
        chk_all("rr_3", 2'd3, 1'b1, 4'b1000, 1'b0);
        step();
        chk_all("rr_end", 2'd0, 1'b0, 4'b0000, 1'b0);
`else
        chk_all("fx_3b", 2'd3, 1'b1, 4'b1111, 1'b0);
        en = 1'b0; d = 4'b0000;
        step();
        chk_all("fx_2", 2'd2, 1'b1, 4'b0111, 1'b0);
        step();
        chk_all("fx_1", 2'd1, 1'b1, 4'b0011, 1'b0);
        step();
        chk_all("fx_0", 2'd0, 1'b1, 4'b0001, 1'b0);
        step();
        chk_all("fx_end", 2'd0, 1'b0, 4'b0000, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/encoder4to2_pend.md
ENCODER4TO2_PEND -- requirements
Module: encoder4to2_pend

Interface
REQ-001 Parameter: IDLE_CODE, 2'b00, value driven on Y whenever V=0.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 D  input  4  request lines; bit i requests code i (inverse of 2-to-4 decoder output Y[i]).
REQ-005 EN  input  1  capture enable; D sampled only when EN=1.
REQ-006 RDY  input  1  consumer accepts current code when V=1.
REQ-007 Y  output  2  encoded index of granted request, registered.
REQ-008 V  output  1  Y valid, registered.
REQ-009 PEND  output  4  pending-request register, registered.
REQ-010 OVF  output  1  sticky flag: request arrived for an already-pending bit.

Function
REQ-011 Pending update each edge: PEND_next = (PEND & ~CLR) | (EN ? D : 4'b0000), where CLR = one-hot(Y) if V&RDY, else 0.
REQ-012 FSM states IDLE (V=0) and PRESENT (V=1); 1-bit state register.
REQ-013 IDLE -> PRESENT when PEND_next != 0; Y loaded with priority pick of PEND_next in the same edge.
REQ-014 Latency: EN=1 with D!=0 sampled at edge k in IDLE -> V=1, Y valid after edge k.
REQ-015 PRESENT with RDY=0: Y and V hold; no preemption by newly arriving higher-priority requests.
REQ-016 PRESENT with RDY=1: bit Y cleared; if PEND_next != 0, stay PRESENT, Y = new pick; else -> IDLE, Y = IDLE_CODE.
REQ-017 Back-to-back: with RDY held 1, a new code is presented every cycle until PEND empty.
REQ-018 Fixed priority (default): highest index wins (D[3] > D[2] > D[1] > D[0]).
REQ-019 Same-edge clear and capture of the same bit: bit remains set (new request wins); OVF not set.
REQ-020 OVF set when EN & D[i] & PEND[i] & ~CLR[i] for any i; cleared only by reset.
REQ-021 RDY while V=0 is ignored; EN=1 with D=0 has no effect.

Reset
REQ-022 RST_N=0 asynchronously forces: state IDLE, PEND=4'b0000, Y=IDLE_CODE, V=0, OVF=0, rotation pointer=0.
REQ-023 Reset asserted mid-transaction discards all pending requests; first edge after RST_N release behaves as IDLE with empty PEND.

Configuration
REQ-024 Macro ENCODER_ROUND_ROBIN_EN defined: rotating priority; search starts at (last granted index - 1) mod 4, descending with wrap; pointer updates on each V&RDY.
REQ-025 Macro undefined: fixed priority per REQ-018; no rotation pointer logic synthesized.

Structure
REQ-026 Package encoder_pkg holds: N_REQ=4, IDX_W=2, state enum {IDLE, PRESENT}.
REQ-027 One combinational sub-module pri_enc4: inputs 4-bit request vector and 2-bit start index, outputs 2-bit index and any-valid flag; start index tied to 3 when macro undefined.
REQ-028 All outputs driven directly from registers.

Verification
REQ-029 Reset: RST_N=0 mid-PRESENT with PEND=4'b1010 -> immediately Y=00, V=0, PEND=0000, OVF=0.
REQ-030 Single request: EN=1, D=4'b0100 one cycle, RDY=0 -> next cycle Y=2, V=1; hold 5 cycles; RDY=1 -> following cycle V=0, Y=00, PEND=0000.
REQ-031 Multi-hot fixed priority: EN=1, D=4'b1011, RDY=1 held -> Y sequence 3,1,0 on consecutive cycles, then V=0.
REQ-032 No preemption: Y=1 presented, RDY=0, EN=1 D=4'b1000 -> Y stays 1 until RDY; next Y=3.
REQ-033 OVF: PEND=4'b0010, V=1 with Y=1, RDY=0, EN=1 D=4'b0010 -> OVF=1 next cycle, persists; repeat with RDY=1 same cycle -> OVF not set, PEND[1] stays 1.
REQ-034 With ENCODER_ROUND_ROBIN_EN: D=4'b1111 captured, then EN=1 D=4'b1000 after first grant, RDY=1 held -> Y sequence 3,2,1,0,3.
